// File: rtl/ecc_enc_dec_core.sv
// ecc_enc_dec_core: extended-Hamming (SECDED) encode / decode / full-channel engine.
// Sits behind the APB register block. Each accepted start snapshots the block's
// registers, and a four-state sequence then produces data_out, num_of_errors and
// a one-cycle operation_done pulse.
//
//   state | meaning
//   IDLE  | waiting for start; snapshot registers on accept
//   LOAD  | working codeword registered (encode, encode+noise, or received word)
//   CALC  | result registered (codeword, or corrected payload plus error class)
//   DONE  | pulse operation_done, drop busy, return to IDLE

module ecc_enc_dec_core #(
    parameter int AMBA_WORD  = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] NOISE,
    output logic [AMBA_WORD-1:0] data_out,
    output logic                 operation_done,
    output logic [1:0]           num_of_errors,
    output logic                 busy
);

    localparam int IDXW = $clog2(DATA_WIDTH);

    localparam logic [1:0] MODE_ENC  = 2'd0;
    localparam logic [1:0] MODE_DEC  = 2'd1;
    localparam logic [1:0] MODE_FULL = 2'd2;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_SINGLE = 2'b01;
    localparam logic [1:0] ERR_DOUBLE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t                 state_q;
    logic [1:0]             mode_q;
    logic [1:0]             width_q;
    logic [DATA_WIDTH-1:0]  din_q;
    logic [DATA_WIDTH-1:0]  noise_q;
    logic [DATA_WIDTH-1:0]  cw_q;
    logic [AMBA_WORD-1:0]   data_out_q;
    logic [1:0]             num_of_errors_q;
    logic                   operation_done_q;
    logic                   busy_q;

    logic [DATA_WIDTH-1:0]  cw_d;
    logic [AMBA_WORD-1:0]   data_d;
    logic [1:0]             err_d;

    // Only the low two bits of CTRL and CODEWORD_WIDTH carry meaning.
    logic unused_ok;
    assign unused_ok = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};

    // Codeword mask: n = 8, 16 or 32 (width codes 2 and 3 both mean 32).
    function automatic logic [DATA_WIDTH-1:0] n_mask(input logic [1:0] w);
        case (w)
            2'd0:    return DATA_WIDTH'(32'h0000_00FF);
            2'd1:    return DATA_WIDTH'(32'h0000_FFFF);
            default: return DATA_WIDTH'(32'hFFFF_FFFF);
        endcase
    endfunction

    // Payload mask: k = 4, 11 or 26.
    function automatic logic [DATA_WIDTH-1:0] k_mask(input logic [1:0] w);
        case (w)
            2'd0:    return DATA_WIDTH'(32'h0000_000F);
            2'd1:    return DATA_WIDTH'(32'h0000_07FF);
            default: return DATA_WIDTH'(32'h03FF_FFFF);
        endcase
    endfunction

    // Data positions are the non-powers-of-two in ascending order. That order is
    // identical for every n, so a masked payload can be spread with one fixed map.
    function automatic logic [DATA_WIDTH-1:0] place_data(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] cw;
        int                    di;
        cw = '0;
        di = 0;
        for (int p = 1; p < DATA_WIDTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p[IDXW-1:0]] = d[di[IDXW-1:0]];
                di++;
            end
        end
        return cw;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract_data(input logic [DATA_WIDTH-1:0] cw);
        logic [DATA_WIDTH-1:0] d;
        int                    di;
        d  = '0;
        di = 0;
        for (int p = 1; p < DATA_WIDTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[di[IDXW-1:0]] = cw[p[IDXW-1:0]];
                di++;
            end
        end
        return d;
    endfunction

    // Positions at or above n hold zero after masking, so each parity bit can be
    // computed over the full bus; parity 16 comes out zero for n below 32.
    function automatic logic [DATA_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [1:0]            w);
        logic [DATA_WIDTH-1:0] cw;
        logic                  par;
        int                    q;
        cw = place_data(d & k_mask(w));
        for (int j = 0; j < IDXW; j++) begin
            q   = 1 << j;
            par = 1'b0;
            for (int p = 1; p < DATA_WIDTH; p++) begin
                if (((p >> j) & 1) == 1 && p != q) begin
                    par = par ^ cw[p[IDXW-1:0]];
                end
            end
            cw[q[IDXW-1:0]] = par;
        end
        cw[0] = ^cw[DATA_WIDTH-1:1];
        return cw & n_mask(w);
    endfunction

    // Working codeword captured on the LOAD edge.
    always_comb begin
        cw_d = '0;
        case (mode_q)
            MODE_ENC:  cw_d = encode(din_q, width_q);
            MODE_FULL: cw_d = encode(din_q, width_q) ^ (noise_q & n_mask(width_q));
            MODE_DEC:  cw_d = din_q & n_mask(width_q);
            default:   cw_d = '0;
        endcase
    end

    // Syndrome, overall parity, correction and payload extraction for the CALC edge.
    always_comb begin
        logic [IDXW-1:0]       syn;
        logic                  par;
        logic [DATA_WIDTH-1:0] fixed;
        syn   = '0;
        par   = ^cw_q;
        fixed = cw_q;
        for (int p = 1; p < DATA_WIDTH; p++) begin
            if (cw_q[p[IDXW-1:0]]) begin
                syn = syn ^ p[IDXW-1:0];
            end
        end
        // Odd overall parity means one flipped bit at position syn (0 = the parity bit itself).
        if (par) begin
            fixed[syn] = ~fixed[syn];
        end
        data_d = '0;
        err_d  = ERR_NONE;
        case (mode_q)
            MODE_ENC: begin
                data_d = AMBA_WORD'(cw_q);
                err_d  = ERR_NONE;
            end
            MODE_DEC, MODE_FULL: begin
                data_d = AMBA_WORD'(extract_data(fixed) & k_mask(width_q));
                if (par) begin
                    err_d = ERR_SINGLE;
                end else if (syn != '0) begin
                    err_d = ERR_DOUBLE;
                end else begin
                    err_d = ERR_NONE;
                end
            end
            default: begin
                data_d = '0;
                err_d  = ERR_NONE;
            end
        endcase
    end

    // Sequencer: snapshot on accept, then LOAD, CALC, DONE with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            mode_q           <= '0;
            width_q          <= '0;
            din_q            <= '0;
            noise_q          <= '0;
            cw_q             <= '0;
            data_out_q       <= '0;
            num_of_errors_q  <= '0;
            operation_done_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    operation_done_q <= 1'b0;
                    if (start) begin
                        mode_q  <= CTRL[1:0];
                        width_q <= CODEWORD_WIDTH[1:0];
                        din_q   <= DATA_IN[DATA_WIDTH-1:0];
                        noise_q <= NOISE[DATA_WIDTH-1:0];
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cw_q    <= cw_d;
                    state_q <= ST_CALC;
                end
                ST_CALC: begin
                    data_out_q      <= data_d;
                    num_of_errors_q <= err_d;
                    state_q         <= ST_DONE;
                end
                ST_DONE: begin
                    operation_done_q <= 1'b1;
                    busy_q           <= 1'b0;
                    state_q          <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out       = data_out_q;
    assign num_of_errors  = num_of_errors_q;
    assign operation_done = operation_done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_ecc_enc_dec_core.sv
// Testbench for ecc_enc_dec_core: vector table plus directed control sequences,
// with a scoreboard queue popped on every operation_done.

module tb_ecc_enc_dec_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] CTRL;
    logic [31:0] DATA_IN;
    logic [31:0] CODEWORD_WIDTH;
    logic [31:0] NOISE;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;
    logic        busy;

    ecc_enc_dec_core #(.AMBA_WORD(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .CTRL           (CTRL),
        .DATA_IN        (DATA_IN),
        .CODEWORD_WIDTH (CODEWORD_WIDTH),
        .NOISE          (NOISE),
        .data_out       (data_out),
        .operation_done (operation_done),
        .num_of_errors  (num_of_errors),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] wcode;
        logic [31:0] din;
        logic [31:0] noise;
        logic [31:0] exp_d;
        logic [1:0]  exp_e;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  e;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic int n_of(input logic [31:0] wcode);
        case (wcode[1:0])
            2'd0:    return 8;
            2'd1:    return 16;
            default: return 32;
        endcase
    endfunction

    // Reference: spread payload, then set parity bits to the syndrome of the data
    // bits so that the full syndrome becomes zero, then even overall parity in bit 0.
    function automatic logic [31:0] m_encode(input logic [31:0] d, input int n);
        logic [31:0] cw;
        logic [4:0]  s;
        int          di;
        int          k;
        int          q;
        k  = (n == 8) ? 4 : ((n == 16) ? 11 : 26);
        cw = '0;
        s  = '0;
        di = 0;
        for (int p = 1; p < n; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (di < k) cw[p[4:0]] = d[di[4:0]];
                di++;
            end
        end
        for (int p = 1; p < n; p++) if (cw[p[4:0]]) s = s ^ p[4:0];
        for (int j = 0; j < 5; j++) begin
            q = 1 << j;
            if (s[j]) cw[q[4:0]] = 1'b1;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [31:0] m_extract(input logic [31:0] cw, input int n);
        logic [31:0] d;
        int          di;
        d  = '0;
        di = 0;
        for (int p = 1; p < n; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[di[4:0]] = cw[p[4:0]];
                di++;
            end
        end
        return d;
    endfunction

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && operation_done) begin
            if (prev_done) begin
                total_cnt++;
                $display("FAIL done_width: operation_done high for more than one cycle, got 2 cycles expected 1");
            end else if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL extra_done: got operation_done with no pending operation, expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data_out", data_out, e.d);
                check("num_of_errors", {30'd0, num_of_errors}, {30'd0, e.e});
            end
        end
        prev_done = operation_done;
    end

    task automatic drive(input logic [31:0] ctrl, input logic [31:0] wcode,
                         input logic [31:0] din, input logic [31:0] noise);
        CTRL           = ctrl;
        CODEWORD_WIDTH = wcode;
        DATA_IN        = din;
        NOISE          = noise;
        start          = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check(name, {31'd0, sb.size() == 0}, 32'd1);
        sb.delete();
    endtask

    task automatic run_op(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        drive(v.ctrl, v.wcode, v.din, v.noise);
        e.d = v.exp_d;
        e.e = v.exp_e;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_drain(name);
    endtask

    initial begin
        exp_t        e;
        vec_t        v;
        logic [31:0] cw32;
        logic [31:0] pay;
        logic [31:0] nz;
        int          b1;
        int          b2;

        rst = 1'b1; start = 1'b0;
        CTRL = '0; DATA_IN = '0; CODEWORD_WIDTH = '0; NOISE = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data_out", data_out, 32'h0);
        check("reset_done", {31'd0, operation_done}, 32'h0);
        check("reset_errors", {30'd0, num_of_errors}, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);

        // Latency: encode n=8 of 0xB; done 4 edges after start, busy for 3 cycles.
        @(negedge clk);
        drive(32'd0, 32'd0, 32'hB, 32'h0);
        e.d = 32'hAA; e.e = 2'b00; sb.push_back(e);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("lat_busy_c%0d", c), {31'd0, busy}, 32'd1);
            check($sformatf("lat_done_c%0d", c), {31'd0, operation_done}, 32'd0);
        end
        @(negedge clk);
        check("lat_done_c4", {31'd0, operation_done}, 32'd1);
        check("lat_busy_c4", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("lat_done_c5", {31'd0, operation_done}, 32'd0);
        check("hold_after_done", data_out, 32'hAA);
        wait_drain("lat_drain");

        cw32 = m_encode(32'h03FF_FFFF, 32);
        pay  = $urandom;
        b1   = $urandom_range(0, 15);
        b2   = $urandom_range(0, 31);
        b1   = $urandom_range(0, 31);
        if (b1 == b2) b2 = (b1 + 7) % 32;
        nz   = (32'h1 << b1) | (32'h1 << b2);

        vecs[0]  = '{32'd2, 32'd0, 32'hB, 32'h08, 32'hB, 2'b01};
        vecs[1]  = '{32'd2, 32'd0, 32'hB, 32'h09, 32'hA, 2'b10};
        vecs[2]  = '{32'd2, 32'd0, 32'hB, 32'h00, 32'hB, 2'b00};
        vecs[3]  = '{32'd1, 32'd0, 32'hAB, 32'h0, 32'hB, 2'b01};
        vecs[4]  = '{32'd1, 32'd0, 32'hAA, 32'h0, 32'hB, 2'b00};
        vecs[5]  = '{32'd0, 32'd1, 32'h7FF, 32'h0, 32'hFFFF, 2'b00};
        vecs[6]  = '{32'd1, 32'd1, 32'hFFFF, 32'h0, 32'h7FF, 2'b00};
        vecs[7]  = '{32'd0, 32'd2, 32'hFFFF_FFFF, 32'h0, cw32, 2'b00};
        vecs[8]  = '{32'd1, 32'd2, cw32, 32'h0, 32'h03FF_FFFF, 2'b00};
        vecs[9]  = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFB, 32'h0, 32'hAA, 2'b00};
        vecs[10] = '{32'd1, 32'd0, 32'hFFFF_FFAB, 32'h0, 32'hB, 2'b01};
        vecs[11] = '{32'd0, 32'd3, pay, 32'h0, m_encode(pay, 32), 2'b00};
        vecs[12] = '{32'd2, 32'd1, pay, (32'h1 << ($urandom_range(0, 15))) | 32'hFFFF_0000,
                     pay & 32'h7FF, 2'b01};
        vecs[13] = '{32'd2, 32'd2, pay, nz, m_extract(m_encode(pay, 32) ^ nz, 32), 2'b10};
        vecs[14] = '{32'd3, 32'd0, 32'hB, 32'h08, 32'h0, 2'b00};
        vecs[15] = '{32'd1, 32'd3, m_encode(pay, 32) ^ (32'h1 << b1), 32'h0,
                     pay & 32'h03FF_FFFF, 2'b01};

        for (int i = 0; i < 16; i++) run_op(vecs[i], $sformatf("vec%0d_done", i));

        // Set a known result, then a second start during LOAD must be ignored.
        v = '{32'd0, 32'd0, 32'hB, 32'h0, 32'hAA, 2'b00};
        run_op(v, "pre_load_done");
        @(negedge clk);
        drive(32'd0, 32'd0, 32'h5, 32'h0);
        e.d = m_encode(32'h5, 8); e.e = 2'b00; sb.push_back(e);
        @(negedge clk);
        drive(32'd1, 32'd1, 32'h1234, 32'h0);
        check("hold_in_load", data_out, 32'hAA);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_restart", {31'd0, busy}, 32'd1);
        wait_drain("restart_drain");
        repeat (6) @(negedge clk);

        // Inputs changed right after acceptance, plus a start in the DONE cycle.
        @(negedge clk);
        drive(32'd2, 32'd1, 32'h3A5, 32'h0000_0100);
        e.d = 32'h3A5; e.e = 2'b01; sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        CTRL = 32'd0; CODEWORD_WIDTH = 32'd2; DATA_IN = 32'hDEAD_BEEF; NOISE = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        drive(32'd0, 32'd0, 32'h7, 32'h0);
        @(negedge clk);
        start = 1'b0;
        wait_drain("snapshot_drain");
        repeat (6) @(negedge clk);

        // Reset asserted while in CALC.
        v = '{32'd2, 32'd0, 32'hB, 32'h08, 32'hB, 2'b01};
        run_op(v, "pre_reset_done");
        @(negedge clk);
        drive(32'd0, 32'd1, 32'h7FF, 32'h0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_data_out", data_out, 32'h0);
        check("rst_errors", {30'd0, num_of_errors}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_done", {31'd0, operation_done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        v = '{32'd1, 32'd0, 32'hAA ^ 32'h40, 32'h0, 32'hB, 2'b01};
        run_op(v, "post_reset_done");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ecc_enc_dec_core.md
Name: ecc_enc_dec_core

Overview:
- Hamming SECDED (extended Hamming) engine directly downstream of the APB register block.
- Consumes that block's CTRL, DATA_IN, CODEWORD_WIDTH and NOISE outputs plus its start strobe.
- Each operation is encode, decode, or full channel (encode, add noise, decode), at codeword width 8, 16 or 32.
- Results and a done flag are registered for the system to sample.

Parameters:
AMBA_WORD, 32, width of register and data buses
DATA_WIDTH, 32, maximum codeword width supported

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle strobe issued by the register block on each CTRL write
CTRL  in  AMBA_WORD  [1:0] = mode: 0 encode, 1 decode, 2 full channel, 3 invalid
DATA_IN  in  AMBA_WORD  payload (encode/full) or received codeword (decode)
CODEWORD_WIDTH  in  AMBA_WORD  [1:0] = width: 0 → n=8, 1 → n=16, 2 or 3 → n=32
NOISE  in  AMBA_WORD  error mask XORed onto codeword in full-channel mode
data_out  out  AMBA_WORD  codeword (encode) or corrected payload (decode/full), zero-extended
operation_done  out  1  one-cycle pulse, results valid
num_of_errors  out  2  00 none, 01 single (corrected), 10 double (uncorrectable)
busy  out  1  high from start acceptance until operation_done

Behaviour:
- Reset, asynchronous on rst=1:
  - FSM returns to IDLE.
  - data_out, operation_done, num_of_errors, busy and all internal snapshot registers are cleared to 0.
  - An operation in flight is abandoned with no operation_done.
- Code layout:
  - Codeword bit i corresponds to Hamming position i.
  - Parity bits sit at positions 1, 2, 4, 8, 16 (those below n).
  - Data bits fill the remaining positions 3, 5, 6, 7, 9, … in ascending order, DATA_IN[0] first.
  - Data width k is 4, 11 or 26 for n = 8, 16, 32.
  - Parity bit at 2^j = XOR of all other positions p (1..n-1) with bit j of p set.
  - Bit 0 = even parity over bits 1..n-1.
- Decode:
  - S = XOR of indices of all set bits in positions 1..n-1.
  - P = XOR of all n bits.
  - S=0, P=0: no error, errors=00.
  - P=1: single error, flip bit S (S=0 flips bit 0), errors=01.
  - S≠0, P=0: double error, errors=10, data extracted uncorrected.
- Input masking: DATA_IN and NOISE bits at and above n (decode/full) or k (encode payload) are ignored.
- FSM states: IDLE → LOAD → CALC → DONE → IDLE.
- IDLE: on start=1, snapshot CTRL, DATA_IN, CODEWORD_WIDTH and NOISE; busy=1; go LOAD.
- LOAD, one edge: register working codeword.
  - Encode/full: encoded payload; full channel additionally XORs NOISE[n-1:0].
  - Decode: DATA_IN[n-1:0].
- CALC, one edge:
  - Encode: data_out = codeword, errors=00.
  - Decode/full: syndrome logic runs, then data_out = corrected k-bit payload and num_of_errors are registered.
  - Invalid mode: data_out=0, errors=00.
- DONE: operation_done=1 for exactly one cycle, busy drops with it, return to IDLE.
- Latency and outputs:
  - start sampled at edge t, so operation_done is high in the cycle after edge t+3.
  - Latency is the same for all modes.
  - data_out and num_of_errors hold their values until the next operation's CALC edge.
- Start handling: start while busy is ignored, with no queuing. start in the DONE cycle is also ignored.
- Register changes mid-operation: changes to the upstream registers after acceptance do not affect the current result, because all inputs are snapshotted.
- Reset mid-operation: follows the reset rule above; a subsequent start works normally.

Test Plan:
- Encode, n=8, DATA_IN=0xB → data_out=0xAA, num_of_errors=00, operation_done exactly 4 edges after start, busy high 3 cycles.
- Full channel, n=8, DATA_IN=0xB:
  - NOISE=0x08 → data_out=0xB, errors=01.
  - NOISE=0x09 → errors=10.
  - NOISE=0x00 → data_out=0xB, errors=00.
- Decode, n=8:
  - DATA_IN=0xAB (bit 0 flipped) → data_out=0xB, errors=01.
  - DATA_IN=0xAA → errors=00.
- Encode, n=16, DATA_IN=0x7FF → data_out=0xFFFF. Decode of 0xFFFF, n=16 → data_out=0x7FF, errors=00.
- Encode, n=32, DATA_IN=0xFFFFFFFF → upper 6 payload bits ignored, data_out equals encode of 0x03FFFFFF. Decode of that result → 0x03FFFFFF, errors=00.
- Control robustness:
  - Second start during LOAD is ignored, one done pulse only.
  - DATA_IN changed after start does not alter result.
  - rst pulse during CALC → all outputs 0, no operation_done, next start completes correctly.
  - CTRL=3 → data_out=0, errors=00, done pulse.
